// File: rtl/led_bar_controller_if.sv
// Front-panel bus for the LED bar sequencer.
// master: panel controls (start/stop/load/load_val/mode) out, status in.
// slave : the sequencer; counter_out/running/tick/done out, controls in.
interface led_bar_controller_if;
    logic       start;
    logic       stop;
    logic       load;
    logic [4:0] load_val;
    logic [1:0] mode;
    logic [4:0] counter_out;
    logic       running;
    logic       tick;
    logic       done;

    modport master (
        output start, stop, load, load_val, mode,
        input  counter_out, running, tick, done
    );

    modport slave (
        input  start, stop, load, load_val, mode,
        output counter_out, running, tick, done
    );
endinterface

// File: rtl/led_bar_controller.sv
// Level sequencer for the 16-LED thermometer bar (up/down/bounce/fill).
// Ports: clk, rst (sync, active-high), bar (slave modport of the bus).
module led_bar_controller #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MAX_LEVEL = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    led_bar_controller_if.slave  bar
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [4:0]    MAX      = 5'(MAX_LEVEL);

    typedef enum logic [1:0] {
        S_STOP = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    mode_q, mode_d;
    logic          running_q;
    logic          tick_q, tick_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        if (bar.load) begin
            cnt_d = (bar.load_val > MAX) ? MAX : bar.load_val;
            pre_d = '0;
        end else if (bar.stop) begin
            // A stop pulse also masks a coincident start while idle.
            state_d = S_STOP;
            pre_d   = '0;
        end else if (bar.start && state_q == S_STOP) begin
            mode_d  = bar.mode;
            pre_d   = '0;
            state_d = (bar.mode == 2'b01) ? S_DOWN : S_UP;
        end else if (state_q != S_STOP) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                tick_d = 1'b1;
                unique case (mode_q)
                    2'b00: cnt_d = (cnt_q >= MAX) ? 5'd0 : cnt_q + 5'd1;
                    2'b01: cnt_d = (cnt_q == 5'd0) ? MAX : cnt_q - 5'd1;
                    2'b10: begin
                        if (state_q == S_UP) begin
                            // Already at the top: turn around immediately.
                            if (cnt_q >= MAX) begin
                                cnt_d   = MAX - 5'd1;
                                state_d = S_DOWN;
                            end else begin
                                cnt_d = cnt_q + 5'd1;
                                if (cnt_q + 5'd1 == MAX)
                                    state_d = S_DOWN;
                            end
                        end else begin
                            if (cnt_q == 5'd0) begin
                                cnt_d   = 5'd1;
                                state_d = S_UP;
                            end else begin
                                cnt_d = cnt_q - 5'd1;
                                if (cnt_q == 5'd1)
                                    state_d = S_UP;
                            end
                        end
                    end
                    2'b11: begin
                        // A fill started at the top restarts from empty.
                        if (cnt_q >= MAX) begin
                            cnt_d = 5'd0;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                            if (cnt_q + 5'd1 == MAX) begin
                                state_d = S_STOP;
                                done_d  = 1'b1;
                            end
                        end
                    end
                endcase
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_STOP;
            cnt_q     <= 5'd0;
            pre_q     <= '0;
            mode_q    <= 2'b00;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            mode_q    <= mode_d;
            running_q <= (state_d != S_STOP);
            tick_q    <= tick_d;
            done_q    <= done_d;
        end
    end

    assign bar.counter_out = cnt_q;
    assign bar.running     = running_q;
    assign bar.tick        = tick_q;
    assign bar.done        = done_q;

endmodule
